// File: rtl/nios_pio_pkg.sv
// Shared definitions for the Nios II PIO slaves: register map and edge-type encodings.
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // prev is the filtered level before the toggle, so prev=0 means a rising edge.
  function automatic logic edge_qualifies(input int edge_type, input logic prev,
                                          input logic toggle);
    case (edge_type)
      EDGE_RISE: return toggle & ~prev;
      EDGE_FALL: return toggle & prev;
      default:   return toggle;
    endcase
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input line: 2-flop synchronizer followed by a consecutive-mismatch debounce filter.
module pio_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic in_bit,
  output logic filtered,
  output logic toggle
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] count;

  // toggle is high in the cycle whose clock edge flips filtered.
  assign toggle = (sync2 != filtered) && (count == CW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      filtered <= 1'b0;
      count    <= '0;
    end else begin
      sync1 <= in_bit;
      sync2 <= sync1;
      if (sync2 == filtered) begin
        count <= '0;
      end else if (toggle) begin
        filtered <= ~filtered;
        count    <= '0;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/nios_encoder_pio.sv
// Avalon-MM input PIO for encoder/bumper lines: debounced data, sticky edge capture,
// maskable level interrupt.
module nios_encoder_pio
  import nios_pio_pkg::*;
#(
  parameter int               WIDTH           = 8,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter int               EDGE_TYPE       = 2,
  parameter logic [WIDTH-1:0] RESET_MASK      = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             HW           = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [HW-1:0] HOLDOFF_INIT = HW'(DEBOUNCE_CYCLES + 2);

  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] toggle;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] clear_bits;
  logic [HW-1:0]    holdoff;
  logic             wr;
  logic             unused_wdata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_line
    pio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .reset   (reset),
      .in_bit  (in_port[i]),
      .filtered(filtered[i]),
      .toggle  (toggle[i])
    );
    assign edge_hit[i] = edge_qualifies(EDGE_TYPE, filtered[i], toggle[i]);
  end

  assign wr           = chipselect & ~write_n;
  assign clear_bits   = (wr && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
  assign unused_wdata = ^writedata;

  // A new edge is ORed in after the clear, so it wins over a same-cycle write-1-clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      holdoff      <= HOLDOFF_INIT;
      irq_mask     <= RESET_MASK;
      edge_capture <= '0;
    end else begin
      if (holdoff != '0) holdoff <= holdoff - HW'(1);
      if (wr && address == ADDR_MASK) irq_mask <= writedata[WIDTH-1:0];
      edge_capture <= (edge_capture & ~clear_bits) | ((holdoff == '0) ? edge_hit : '0);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = filtered;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_nios_encoder_pio.sv
// Scoreboard bench: three PIO variants share one bus and input stimulus; a window-based
// reference model predicts register contents and irq.
module tb_nios_encoder_pio;

  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [1:0]  address = 2'd0;
  logic [31:0] writedata = 32'd0;
  logic [7:0]  in_port = 8'hFF;
  logic [NI-1:0][31:0] rd;
  logic [NI-1:0]       irq_v;

  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  always #5 clk = ~clk;

  nios_encoder_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2), .RESET_MASK(8'h00)) u_dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[0]), .irq(irq_v[0]));
  nios_encoder_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(1), .EDGE_TYPE(1), .RESET_MASK(8'hA5)) u_dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[1]), .irq(irq_v[1]));
  nios_encoder_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(3), .EDGE_TYPE(0), .RESET_MASK(8'h0F)) u_dut_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .in_port(in_port), .readdata(rd[2]), .irq(irq_v[2]));

  function automatic int dcy(input int i);
    return (i == 0) ? 4 : (i == 1) ? 1 : 3;
  endfunction
  function automatic int ety(input int i);
    return (i == 0) ? 2 : (i == 1) ? 1 : 0;
  endfunction
  function automatic logic [7:0] rmask(input int i);
    return (i == 0) ? 8'h00 : (i == 1) ? 8'hA5 : 8'h0F;
  endfunction

  // Reference model: a line's filtered value flips when the last D synchronized samples
  // (input delayed two clocks) all disagree with it. Edges are ignored for the first D+2
  // clocks after reset.
  logic [7:0] m_filt [NI];
  logic [7:0] m_cap  [NI];
  logic [7:0] m_mask [NI];
  logic [7:0] hist [$];
  int         n_edges;
  logic [7:0] tog, qual, clr;

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      m_filt[i] = 8'h00;
      m_cap[i]  = 8'h00;
      m_mask[i] = rmask(i);
    end
    hist.delete();
    repeat (8) hist.push_back(8'h00);
    n_edges = 0;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      model_reset();
    end else begin
      hist.push_back(in_port);
      if (hist.size() > 16) void'(hist.pop_front());
      n_edges++;
      for (int i = 0; i < NI; i++) begin
        tog = 8'hFF;
        for (int m = 2; m <= 1 + dcy(i); m++) tog &= hist[hist.size() - 1 - m] ^ m_filt[i];
        case (ety(i))
          0:       qual = tog & ~m_filt[i];
          1:       qual = tog & m_filt[i];
          default: qual = tog;
        endcase
        if (n_edges <= dcy(i) + 2) qual = 8'h00;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata[7:0] : 8'h00;
        m_cap[i] = (m_cap[i] & ~clr) | qual;
        if (chipselect && !write_n && address == 2'd2) m_mask[i] = writedata[7:0];
        m_filt[i] ^= tog;
      end
    end
  end

  function automatic logic [31:0] model_read(input int i, input logic [1:0] a);
    case (a)
      2'd0:    return {24'd0, m_filt[i]};
      2'd2:    return {24'd0, m_mask[i]};
      2'd3:    return {24'd0, m_cap[i]};
      default: return 32'd0;
    endcase
  endfunction

  typedef struct packed {
    logic [1:0]          addr;
    logic [NI-1:0][31:0] data;
  } exp_t;
  exp_t sb [$];
  exp_t e;

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < NI; i++) begin
        checks++;
        if (irq_v[i] !== |(m_cap[i] & m_mask[i])) begin
          errors++;
          $display("FAIL irq dut%0d t=%0t got=%b exp=%b", i, $time, irq_v[i],
                   |(m_cap[i] & m_mask[i]));
        end
      end
      if (chipselect && write_n) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty t=%0t got=read exp=queued_entry", $time);
        end else begin
          e = sb.pop_front();
          for (int i = 0; i < NI; i++) begin
            checks++;
            if (rd[i] !== e.data[i]) begin
              errors++;
              $display("FAIL readdata dut%0d addr=%0d t=%0t got=%h exp=%h", i, e.addr, $time,
                       rd[i], e.data[i]);
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic cs, input logic wn, input logic [1:0] a,
                         input logic [31:0] d);
    exp_t x;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = d;
    if (cs && wn) begin
      x.addr = a;
      for (int i = 0; i < NI; i++) x.data[i] = model_read(i, a);
      sb.push_back(x);
    end
  endtask

  task automatic bus_rd(input logic [1:0] a);
    set_bus(1'b1, 1'b1, a, 32'd0);
    cyc();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    set_bus(1'b1, 1'b0, a, d);
    cyc();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      set_bus(1'b0, 1'b1, 2'd0, 32'd0);
      cyc();
    end
  endtask

  task automatic rd_all();
    bus_rd(2'd0);
    bus_rd(2'd1);
    bus_rd(2'd2);
    bus_rd(2'd3);
  endtask

  initial begin
    reset   = 1'b1;
    in_port = 8'hFF;
    repeat (3) cyc();
    started = 1'b1;
    reset   = 1'b0;
    // Lines high out of reset: data follows, hold-off keeps edge_capture clear.
    repeat (12) begin
      bus_rd(2'd0);
      bus_rd(2'd3);
    end
    rd_all();

    in_port = 8'h00;
    idle(8);
    bus_wr(2'd3, 32'hFFFF_FFFF);
    bus_wr(2'd2, 32'h0000_0001);
    in_port[0] = 1'b1;
    repeat (4) begin
      bus_rd(2'd0);
      bus_rd(2'd3);
    end

    // 3-sample glitch must vanish, 4-sample pulse must register on the D=4 variant.
    bus_wr(2'd2, 32'h0000_00FF);
    in_port[3] = 1'b1;
    idle(3);
    in_port[3] = 1'b0;
    repeat (5) bus_rd(2'd3);
    bus_wr(2'd3, 32'h0000_00FF);
    in_port[3] = 1'b1;
    idle(4);
    in_port[3] = 1'b0;
    repeat (6) bus_rd(2'd3);
    rd_all();

    bus_wr(2'd3, 32'h0000_0004);
    bus_rd(2'd3);
    bus_wr(2'd2, 32'h0000_0001);
    bus_rd(2'd2);

    // Clear of bit1 lands on the same edge that captures its rise in the D=4 variant.
    bus_wr(2'd3, 32'h0000_00FF);
    in_port[1] = 1'b1;
    idle(5);
    bus_wr(2'd3, 32'h0000_0002);
    bus_rd(2'd3);

    in_port[2] = 1'b1;
    idle(6);
    bus_rd(2'd3);
    in_port[2] = 1'b0;
    idle(6);
    bus_rd(2'd3);

    in_port = in_port ^ 8'h30;
    idle(2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd_all();
    idle(3);
    rd_all();

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 1) == 0) in_port = in_port ^ 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
      end else begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: bus_rd(2'($urandom_range(0, 3)));
          6, 7:             bus_wr(2'($urandom_range(0, 3)), $urandom());
          default:          idle(1);
        endcase
      end
    end
    idle(10);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
